// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe
//   NUM_IN:1 operand selector feeding a two-entry skid buffer with a
//   valid/ready handshake and flush. Sits between source selection
//   (register file, EX/MEM and MEM/WB forwards, immediate) and the
//   consuming pipeline stage.
//
// Parameters
//   WIDTH   data width per input channel
//   NUM_IN  number of input channels (2..16)
//   SEL_W   select width, derived from NUM_IN (do not override)
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_bus               packed channels, channel k = in_bus[k*WIDTH +: WIDTH]
//   sel                  channel select, sampled on accept
//   in_valid / in_ready  upstream handshake (in_ready registered)
//   flush                drop all held entries and any same-cycle transfer
//   out_data / out_sel   head-of-buffer data and the sel it was captured with
//   out_valid/out_ready  downstream handshake
//   occupancy            held entries (0, 1, 2)
//   sel_err              sticky out-of-range select flag
//
// Build option
//   OPERAND_MUX_SEL_CHECK_EN  when defined, sel_err latches on an accepted
//                             sel >= NUM_IN; otherwise sel_err is tied to 0.

module operand_mux_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              occupancy,
  output logic                    sel_err
);

  // State encoding equals the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] sel_data_c;
  logic             accept_c;
  logic             consume_c;

  // Channel mux; any select that matches no channel falls back to channel 0.
  always_comb begin
    sel_data_c = in_bus[WIDTH-1:0];
    for (int k = 1; k < int'(NUM_IN); k++) begin
      if (sel == SEL_W'(k)) sel_data_c = in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Handshakes are suppressed while flushing.
  assign accept_c  = in_valid && in_ready_q && !flush;
  assign consume_c = out_valid_q && out_ready && !flush;

  // Buffer next-state: main entry drives the outputs, skid holds the second.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          main_data_d = sel_data_c;
          main_sel_d  = sel;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept_c && consume_c) begin
          main_data_d = sel_data_c;
          main_sel_d  = sel;
        end else if (accept_c) begin
          skid_data_d = sel_data_c;
          skid_sel_d  = sel;
          state_d     = ST_FULL;
        end else if (consume_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume_c) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only invalidates entries; data/sel registers keep their contents.
    if (flush) state_d = ST_EMPTY;
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef OPERAND_MUX_SEL_CHECK_EN
  logic sel_oor_c;
  logic sel_err_q, sel_err_d;

  // Out-of-range when the select matches no implemented channel.
  always_comb begin
    sel_oor_c = 1'b1;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (sel == SEL_W'(k)) sel_oor_c = 1'b0;
    end
    sel_err_d = sel_err_q || (accept_c && sel_oor_c);
  end

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign occupancy = state_q;

endmodule
